// File: rtl/sd_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_pkg
// Shared definitions for the SD/eMMC command-line engine:
//   - FSM state encoding
//   - response-type codes
//   - frame-length constants
//   - CRC7 polynomial
//   - response CRC coverage window helper
// ---------------------------------------------------------------------------
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX       = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_RX       = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    // Code 2'b11 is decoded exactly like RSP_48.
    typedef enum logic [1:0] {
        RSP_NONE   = 2'b00,
        RSP_48     = 2'b01,
        RSP_136    = 2'b10,
        RSP_48_ALT = 2'b11
    } rsp_type_t;

    localparam int CMD_FRAME_LEN = 48;   // command and short response frame
    localparam int RSP_LONG_LEN  = 136;  // long (R2) response frame
    localparam int CRC_CMD_BITS  = 40;   // bits covered by CRC7 in a 48-bit frame
    localparam int CRC_LONG_BITS = 120;  // bits covered by CRC7 in a 136-bit frame
    localparam int RSP_HDR_BITS  = 8;    // long-response header, not CRC covered
    localparam int RSP_W         = RSP_LONG_LEN - 2;  // start and end bit dropped
    localparam int TURNAROUND    = 2;    // CMD line turnaround, cmd_i ignored

    localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1, x^7 implicit

    localparam logic [7:0] TX_CRC_FIRST  = 8'(CRC_CMD_BITS);
    localparam logic [7:0] TX_LAST_BIT   = 8'(CMD_FRAME_LEN - 1);
    localparam logic [7:0] RX_SHORT_BITS = 8'(CMD_FRAME_LEN - 2);
    localparam logic [7:0] RX_LONG_BITS  = 8'(RSP_LONG_LEN - 2);

    // rx_idx counts bits received after the start bit. The start bit is a 0
    // fed into a zero-initialised CRC, so clearing the CRC on RX entry is
    // equivalent to having shifted the start bit in.
    function automatic logic rsp_crc_window(input logic is_long,
                                            input logic [7:0] rx_idx);
        if (is_long) begin
            return (rx_idx >= 8'(RSP_HDR_BITS - 1)) &&
                   (rx_idx <  8'(RSP_HDR_BITS - 1 + CRC_LONG_BITS));
        end
        return rx_idx < 8'(CRC_CMD_BITS - 1);
    endfunction

endpackage

// File: rtl/sd_crc_7.sv
// ---------------------------------------------------------------------------
// sd_crc_7
// Serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enabled clock.
// The same instance computes the outgoing command CRC and, afterwards,
// the incoming response CRC.
//
// Ports:
//   sd_clk   - clock, rising edge
//   AXI_RST  - asynchronous active-low reset
//   clr      - synchronous clear to zero (has priority over en)
//   en       - shift din into the CRC this cycle
//   din      - serial data bit, MSB first
//   crc      - current CRC7 remainder
// ---------------------------------------------------------------------------
module sd_crc_7
    import sd_cmd_pkg::*;
(
    input  logic       sd_clk,
    input  logic       AXI_RST,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge sd_clk or negedge AXI_RST) begin
        if (!AXI_RST) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/sd_cmd_serial_host.sv
// ---------------------------------------------------------------------------
// sd_cmd_serial_host
// SD/eMMC CMD-line engine, clocked by the divided SD clock.
//
// Operation:
//   - Sends a 48-bit command: start bit, CRC7, end bit.
//   - Optionally waits for a 48- or 136-bit response and deserialises it.
//   - Reports done, timeout and CRC status.
//
// Optional feature, enabled by defining SD_CMD_RSP_CRC_CHECK_EN:
//   response CRC7 and end-bit checking. When undefined, crc_err_o is tied 0.
//
// Parameters:
//   TIMEOUT_CYCLES - sd_clk cycles in WAIT_RSP before declaring no response
//   GAP_CYCLES     - idle sd_clk cycles after each transaction before done_o
//
// Ports:
//   sd_clk       in   clock, rising edge
//   AXI_RST      in   asynchronous active-low reset
//   start_i      in   one-cycle command request, honoured only in IDLE
//   cmd_index_i  in   [5:0] command index
//   cmd_arg_i    in   [31:0] command argument
//   rsp_type_i   in   [1:0] 00 none, 01 48-bit, 10 136-bit, 11 as 01
//   busy_o       out  transaction in progress
//   done_o       out  one-cycle pulse at transaction end
//   timeout_o    out  no response start bit seen; held until next start
//   crc_err_o    out  response CRC7 / end-bit error; held until next start
//   rsp_o        out  [133:0] response bits after start bit, right-aligned
//   cmd_o        out  CMD line drive value
//   cmd_oe_o     out  CMD line output enable
//   cmd_i        in   CMD line sampled value
// ---------------------------------------------------------------------------
module sd_cmd_serial_host
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 8
) (
    input  logic             sd_clk,
    input  logic             AXI_RST,
    input  logic             start_i,
    input  logic [5:0]       cmd_index_i,
    input  logic [31:0]      cmd_arg_i,
    input  logic [1:0]       rsp_type_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             crc_err_o,
    output logic [RSP_W-1:0] rsp_o,
    output logic             cmd_o,
    output logic             cmd_oe_o,
    input  logic             cmd_i
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_TURN = WAIT_W'(TURNAROUND);
    localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t                  state, state_n;
    logic [CRC_CMD_BITS-1:0] tx_shift;   // start, transmission, index, arg
    logic                    has_rsp;
    logic                    is_long;
    logic [7:0]              bit_cnt;    // position within TX, RX or GAP
    logic [WAIT_W-1:0]       wait_cnt;   // cycles spent in WAIT_RSP
    logic                    timeout_q;
    logic [7:0]              rx_len;
    logic                    start_ok;
    logic                    crc_clr, crc_en, crc_din;
    logic [6:0]              crc;

    assign start_ok  = (state == ST_IDLE) && start_i;
    assign rx_len    = is_long ? RX_LONG_BITS : RX_SHORT_BITS;
    // Combinational from state so a reset releases the line immediately.
    assign busy_o    = (state != ST_IDLE);
    assign timeout_o = timeout_q;

    sd_crc_7 u_crc (
        .sd_clk  (sd_clk),
        .AXI_RST (AXI_RST),
        .clr     (crc_clr),
        .en      (crc_en),
        .din     (crc_din),
        .crc     (crc)
    );

    always_ff @(posedge sd_clk or negedge AXI_RST) begin
        if (!AXI_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_n  = state;
        cmd_o    = 1'b1;
        cmd_oe_o = 1'b0;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        crc_din  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_n = ST_TX;
                    crc_clr = 1'b1;
                end
            end
            ST_TX: begin
                cmd_oe_o = 1'b1;
                if (bit_cnt < TX_CRC_FIRST) begin
                    cmd_o   = tx_shift[CRC_CMD_BITS-1];
                    crc_en  = 1'b1;
                    crc_din = tx_shift[CRC_CMD_BITS-1];
                end else if (bit_cnt < TX_LAST_BIT) begin
                    // Bits 40..46 carry crc[6]..crc[0].
                    cmd_o = crc[3'(TX_LAST_BIT - 8'd1 - bit_cnt)];
                end
                if (bit_cnt == TX_LAST_BIT) begin
                    state_n = has_rsp ? ST_WAIT_RSP : ST_GAP;
                end
            end
            ST_WAIT_RSP: begin
                // A start bit on the final cycle wins over the timeout.
                if (wait_cnt >= WAIT_TURN && !cmd_i) begin
                    state_n = ST_RX;
`ifdef SD_CMD_RSP_CRC_CHECK_EN
                    crc_clr = 1'b1;
`endif
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = ST_GAP;
                end
            end
            ST_RX: begin
                if (bit_cnt == rx_len) begin
                    state_n = ST_GAP;  // this cycle samples the end bit
                end
`ifdef SD_CMD_RSP_CRC_CHECK_EN
                else if (rsp_crc_window(is_long, bit_cnt)) begin
                    crc_en  = 1'b1;
                    crc_din = cmd_i;
                end
`endif
            end
            ST_GAP: begin
                if (bit_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: rsp_o is a plain register, not a memory, so it takes the async
    // reset along with the rest of the datapath.
    always_ff @(posedge sd_clk or negedge AXI_RST) begin
        if (!AXI_RST) begin
            tx_shift  <= '0;
            has_rsp   <= 1'b0;
            is_long   <= 1'b0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            rsp_o     <= '0;
            timeout_q <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= (state == ST_GAP) && (state_n == ST_IDLE);

            if (state_n != state) begin
                bit_cnt <= '0;
            end else if (state != ST_IDLE) begin
                bit_cnt <= bit_cnt + 8'd1;
            end

            if (state_n != state) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT_RSP && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (start_ok) begin
                tx_shift  <= {2'b01, cmd_index_i, cmd_arg_i};
                has_rsp   <= (rsp_type_i != RSP_NONE);
                is_long   <= (rsp_type_i == RSP_136);
                rsp_o     <= '0;
                timeout_q <= 1'b0;
            end else if (state == ST_TX && bit_cnt < TX_CRC_FIRST) begin
                tx_shift <= {tx_shift[CRC_CMD_BITS-2:0], 1'b0};
            end

            if (state == ST_WAIT_RSP && state_n == ST_GAP) begin
                timeout_q <= 1'b1;
            end

            if (state == ST_RX && bit_cnt < rx_len) begin
                rsp_o <= {rsp_o[RSP_W-2:0], cmd_i};
            end
        end
    end

`ifdef SD_CMD_RSP_CRC_CHECK_EN
    logic crc_err_q;

    // Evaluated while the end bit is on cmd_i; the received CRC field has
    // just landed in rsp_o[6:0].
    always_ff @(posedge sd_clk or negedge AXI_RST) begin
        if (!AXI_RST) begin
            crc_err_q <= 1'b0;
        end else if (start_ok) begin
            crc_err_q <= 1'b0;
        end else if (state == ST_RX && bit_cnt == rx_len) begin
            crc_err_q <= (crc != rsp_o[6:0]) || !cmd_i;
        end
    end

    assign crc_err_o = crc_err_q;
`else
    assign crc_err_o = 1'b0;
`endif

endmodule
